// File: rtl/setup_menu_n_pkg.sv
// Shared types and constants for the lock setup menu: digit packs, the
// configuration record, reserved keypad codes and the menu state encoding.
package setup_menu_n_pkg;

  typedef logic [19:0][3:0] senhaPac_t;
  typedef logic [5:0][3:0]  bcdPac_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranca_aut_time;
    senhaPac_t  senha_master;
  } setupCfg_t;

  // A reserved code is one hex value repeated over all 20 digits.
  localparam logic [3:0] CODE_SKIP   = 4'hF;
  localparam logic [3:0] CODE_SAVE   = 4'hB;
  localparam logic [3:0] CODE_BACK   = 4'hA;
  localparam logic [3:0] CODE_CANCEL = 4'hC;
  localparam logic [3:0] CODE_IGNORE = 4'hE;

  localparam senhaPac_t DEF_MASTER = {{16{4'hF}}, 16'h1234};
  localparam senhaPac_t DEF_USER   = '1;
  localparam logic      DEF_BIP    = 1'b1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_BIP_EN,
    S_BIP_TIME,
    S_TRC_TIME,
    S_PASS_MASTER,
    S_PASS_USER,
    S_SAVE,
    S_ABORT
  } state_t;

  function automatic logic is_code(input senhaPac_t v, input logic [3:0] c);
    return v == senhaPac_t'({20{c}});
  endfunction

endpackage

// File: rtl/setup_menu_n_pass_check.sv
// Combinational password validation: BCD digits followed only by trailing F,
// at least MIN_PASS_LEN digits long; stored value keeps MAX_PASS_LEN digits.
module pass_check
  import setup_menu_n_pkg::*;
#(
  parameter int unsigned MIN_PASS_LEN = 4,
  parameter int unsigned MAX_PASS_LEN = 12
) (
  input  senhaPac_t i_value,
  output logic      o_valid,
  output senhaPac_t o_stored
);

  logic w_seen_f;
  logic w_ok;

  // Scan from the newest digit upward: once an F is seen, only F may follow.
  always_comb begin
    w_seen_f = 1'b0;
    w_ok     = (i_value[MIN_PASS_LEN-1] != 4'hF);
    o_stored = '1;
    for (int unsigned i = 0; i < MAX_PASS_LEN; i++) begin
      o_stored[i] = i_value[i];
      if (i_value[i] == 4'hF) begin
        w_seen_f = 1'b1;
      end else if ((i_value[i] > 4'd9) || w_seen_f) begin
        w_ok = 1'b0;
      end
    end
    o_valid = w_ok;
  end

endmodule

// File: rtl/setup_menu_n.sv
// Installer setup menu: walks beep/auto-lock settings and passwords on a
// shadow copy that is committed on save and discarded on cancel or timeout.
module setup_menu_n
  import setup_menu_n_pkg::*;
#(
  parameter int unsigned N_USERS      = 4,
  parameter int unsigned MIN_TIME     = 5,
  parameter int unsigned MAX_TIME     = 60,
  parameter int unsigned MIN_PASS_LEN = 4,
  parameter int unsigned MAX_PASS_LEN = 12,
  parameter int unsigned TIMEOUT_CYC  = 30_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     setup_on,
  input  senhaPac_t                digitos_value,
  input  logic                     digitos_valid,
  input  setupCfg_t                cfg_cur,
  input  senhaPac_t [N_USERS-1:0]  senha_users_cur,
  output logic                     display_en,
  output bcdPac_t                  bcd_pac,
  output setupCfg_t                cfg_new,
  output senhaPac_t [N_USERS-1:0]  senha_users_new,
  output logic                     data_setup_ok,
  output logic                     setup_abort
);

  localparam int unsigned IW = (N_USERS > 1) ? $clog2(N_USERS) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [6:0]  MIN_T = 7'(MIN_TIME);
  localparam logic [6:0]  MAX_T = 7'(MAX_TIME);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_USERS - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam setupCfg_t CFG_DEFAULT = '{
    bip_status:      DEF_BIP,
    bip_time:        MIN_T,
    tranca_aut_time: MIN_T,
    senha_master:    DEF_MASTER
  };

  state_t                  r_state, w_state_nx;
  logic [IW-1:0]           r_idx, w_idx_nx;
  logic [TW-1:0]           r_timer, w_timer_nx;
  setupCfg_t               r_cfg, w_cfg_nx;
  senhaPac_t [N_USERS-1:0] r_users, w_users_nx;

  logic       w_strobe, w_adv, w_back;
  logic       w_tok;
  logic [6:0] w_tval, w_tclamp;
  logic       w_pass_ok;
  senhaPac_t  w_pass_val;
  bcdPac_t    w_bcd;
  logic [3:0] w_step;
  logic       w_has_step;

  pass_check #(
    .MIN_PASS_LEN(MIN_PASS_LEN),
    .MAX_PASS_LEN(MAX_PASS_LEN)
  ) u_pass_check (
    .i_value (digitos_value),
    .o_valid (w_pass_ok),
    .o_stored(w_pass_val)
  );

  assign w_strobe = digitos_valid && !is_code(digitos_value, CODE_IGNORE);
  assign w_tok    = (digitos_value[1] <= 4'd9) && (digitos_value[0] <= 4'd9);
  assign w_tval   = 7'(digitos_value[1]) * 7'd10 + 7'(digitos_value[0]);
  assign w_tclamp = (w_tval < MIN_T) ? MIN_T : ((w_tval > MAX_T) ? MAX_T : w_tval);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_timer <= '0;
      r_cfg   <= CFG_DEFAULT;
      r_users <= '1;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;
      r_timer <= w_timer_nx;
      r_cfg   <= w_cfg_nx;
      r_users <= w_users_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_timer_nx = r_timer;
    w_cfg_nx   = r_cfg;
    w_users_nx = r_users;
    w_adv      = 1'b0;
    w_back     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_timer_nx = '0;
        if (setup_on) w_state_nx = S_LOAD;
      end
      S_LOAD: begin
        w_timer_nx = r_timer + TW'(1);
        w_cfg_nx   = cfg_cur;
        w_users_nx = senha_users_cur;
        w_state_nx = S_BIP_EN;
      end
      S_SAVE: w_state_nx = S_IDLE;
      S_ABORT: begin
        w_cfg_nx   = cfg_cur;
        w_users_nx = senha_users_cur;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_timer_nx = r_timer + TW'(1);
        // A real strobe takes priority over a timeout landing on the same cycle.
        if (w_strobe) begin
          w_timer_nx = '0;
          if (is_code(digitos_value, CODE_SKIP)) begin
            w_adv = 1'b1;
          end else if (is_code(digitos_value, CODE_SAVE)) begin
            w_state_nx = S_SAVE;
          end else if (is_code(digitos_value, CODE_BACK)) begin
            w_back = 1'b1;
          end else if (is_code(digitos_value, CODE_CANCEL)) begin
            w_state_nx = S_ABORT;
          end else begin
            case (r_state)
              S_BIP_EN: if (digitos_value[0] <= 4'd1) begin
                w_cfg_nx.bip_status = digitos_value[0][0];
                w_adv = 1'b1;
              end
              S_BIP_TIME: if (w_tok) begin
                w_cfg_nx.bip_time = w_tclamp;
                w_adv = 1'b1;
              end
              S_TRC_TIME: if (w_tok) begin
                w_cfg_nx.tranca_aut_time = w_tclamp;
                w_adv = 1'b1;
              end
              S_PASS_MASTER: if (w_pass_ok) begin
                w_cfg_nx.senha_master = w_pass_val;
                w_adv = 1'b1;
              end
              S_PASS_USER: if (w_pass_ok) begin
                w_users_nx[r_idx] = w_pass_val;
                w_adv = 1'b1;
              end
              default: ;
            endcase
          end
        end else if (r_timer == TMO_LAST) begin
          w_state_nx = S_ABORT;
        end

        if (w_adv) begin
          case (r_state)
            S_BIP_EN:   w_state_nx = S_BIP_TIME;
            S_BIP_TIME: w_state_nx = S_TRC_TIME;
            S_TRC_TIME: w_state_nx = S_PASS_MASTER;
            S_PASS_MASTER: begin
              w_state_nx = S_PASS_USER;
              w_idx_nx   = '0;
            end
            S_PASS_USER: begin
              if (r_idx == LAST_IDX) w_state_nx = S_SAVE;
              else                   w_idx_nx   = r_idx + IW'(1);
            end
            default: ;
          endcase
        end

        if (w_back) begin
          case (r_state)
            S_BIP_TIME:    w_state_nx = S_BIP_EN;
            S_TRC_TIME:    w_state_nx = S_BIP_TIME;
            S_PASS_MASTER: w_state_nx = S_TRC_TIME;
            S_PASS_USER: begin
              if (r_idx == '0) w_state_nx = S_PASS_MASTER;
              else             w_idx_nx   = r_idx - IW'(1);
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    w_bcd      = '1;
    w_step     = 4'd0;
    w_has_step = 1'b1;
    case (r_state)
      S_BIP_EN: begin
        w_step   = 4'd1;
        w_bcd[0] = digitos_value[0];
      end
      S_BIP_TIME: begin
        w_step     = 4'd2;
        w_bcd[1:0] = digitos_value[1:0];
      end
      S_TRC_TIME: begin
        w_step     = 4'd3;
        w_bcd[1:0] = digitos_value[1:0];
      end
      S_PASS_MASTER: w_step = 4'd4;
      S_PASS_USER:   w_step = 4'd5 + 4'(r_idx);
      default:       w_has_step = 1'b0;
    endcase
    if (w_has_step) begin
      w_bcd[5] = (w_step >= 4'd10) ? 4'd1 : 4'd0;
      w_bcd[4] = (w_step >= 4'd10) ? (w_step - 4'd10) : w_step;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      display_en    <= 1'b0;
      bcd_pac       <= '1;
      data_setup_ok <= 1'b0;
      setup_abort   <= 1'b0;
    end else begin
      display_en    <= (r_state != S_IDLE) && (r_state != S_ABORT);
      bcd_pac       <= w_bcd;
      data_setup_ok <= (r_state == S_SAVE);
      setup_abort   <= (r_state == S_ABORT);
    end
  end

  assign cfg_new         = r_cfg;
  assign senha_users_new = r_users;

endmodule

// File: tb/tb_setup_menu_n.sv
// Scoreboard bench for setup_menu_n: commit/abort events checked by a monitor
// against expectations queued by the stimulus; display checks inline.
module tb_setup_menu_n;
  import setup_menu_n_pkg::*;

  localparam int unsigned NU = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               setup_on = 1'b0;
  logic               digitos_valid = 1'b0;
  senhaPac_t          digitos_value = '1;
  setupCfg_t          cfg_cur;
  senhaPac_t [NU-1:0] users_cur;
  logic               display_en;
  bcdPac_t            bcd_pac;
  setupCfg_t          cfg_new;
  senhaPac_t [NU-1:0] users_new;
  logic               data_setup_ok;
  logic               setup_abort;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit                 is_ok;
    setupCfg_t          cfg;
    senhaPac_t [NU-1:0] users;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  setup_menu_n #(
    .N_USERS(NU),
    .MIN_TIME(5),
    .MAX_TIME(60),
    .MIN_PASS_LEN(4),
    .MAX_PASS_LEN(12),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .setup_on       (setup_on),
    .digitos_value  (digitos_value),
    .digitos_valid  (digitos_valid),
    .cfg_cur        (cfg_cur),
    .senha_users_cur(users_cur),
    .display_en     (display_en),
    .bcd_pac        (bcd_pac),
    .cfg_new        (cfg_new),
    .senha_users_new(users_new),
    .data_setup_ok  (data_setup_ok),
    .setup_abort    (setup_abort)
  );

  task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic senhaPac_t code(input logic [3:0] c);
    senhaPac_t v;
    for (int i = 0; i < 20; i++) v[i] = c;
    return v;
  endfunction

  function automatic senhaPac_t dig(input logic [15:0] hex, input int n);
    senhaPac_t v;
    v = '1;
    for (int i = 0; i < n; i++) v[i] = hex[4*i +: 4];
    return v;
  endfunction

  function automatic exp_t mk(input bit ok, input setupCfg_t c, input senhaPac_t [NU-1:0] u);
    exp_t e;
    e.is_ok = ok;
    e.cfg   = c;
    e.users = u;
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input senhaPac_t v);
    digitos_value = v;
    digitos_valid = 1'b1;
    tick();
    digitos_valid = 1'b0;
  endtask

  task automatic start();
    setup_on = 1'b1;
    tick();
    setup_on = 1'b0;
    tick();
    tick();
  endtask

  task automatic chk_step(input string name, input logic [7:0] exp);
    check(name, 320'(bcd_pac[5:4]), 320'(exp));
  endtask

  always @(negedge clk) begin
    if (data_setup_ok || setup_abort) begin
      if (sb_q.size() == 0) begin
        check("unexpected_event", 320'({data_setup_ok, setup_abort}), 320'(0));
      end else begin
        mon_e = sb_q.pop_front();
        check("event_kind", 320'({data_setup_ok, setup_abort}),
              320'(mon_e.is_ok ? 2'b10 : 2'b01));
        check("cfg_new", 320'(cfg_new), 320'(mon_e.cfg));
        check("users_new", 320'(users_new), 320'(mon_e.users));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    setupCfg_t          factory, c_exp;
    senhaPac_t [NU-1:0] u_exp;
    int                 n;

    factory = '{bip_status: 1'b1, bip_time: 7'd5, tranca_aut_time: 7'd5,
                senha_master: dig(16'h1234, 4)};
    cfg_cur = '{bip_status: 1'b0, bip_time: 7'd20, tranca_aut_time: 7'd30,
                senha_master: dig(16'h9999, 4)};
    users_cur[0] = dig(16'h1111, 4);
    users_cur[1] = dig(16'h2222, 4);
    users_cur[2] = dig(16'h3333, 4);
    users_cur[3] = dig(16'h4444, 4);

    repeat (3) tick();
    check("rst_display_en", 320'(display_en), 320'(0));
    check("rst_ok", 320'(data_setup_ok), 320'(0));
    check("rst_abort", 320'(setup_abort), 320'(0));
    check("rst_bcd", 320'(bcd_pac), 320'(24'hFFFFFF));
    check("rst_cfg", 320'(cfg_new), 320'(factory));
    check("rst_users", 320'(users_new), {320{1'b1}});
    rst = 1'b1;
    tick();

    // Full walk with clamp at the top of the time range
    start();
    chk_step("load_step", 8'h01);
    check("load_display_en", 320'(display_en), 320'(1));
    check("load_cfg", 320'(cfg_new), 320'(cfg_cur));
    send(dig(16'h0001, 1));
    digitos_value = dig(16'h0007, 2);
    tick();
    check("bip_time_display", 320'(bcd_pac), 320'(24'h02FF07));
    send(dig(16'h0007, 2));
    send(dig(16'h0075, 2));
    tick();
    check("master_masked", 320'(bcd_pac), 320'(24'h04FFFF));
    c_exp = '{bip_status: 1'b1, bip_time: 7'd7, tranca_aut_time: 7'd60,
              senha_master: dig(16'h5678, 4)};
    sb_q.push_back(mk(1'b1, c_exp, users_cur));
    send(dig(16'h5678, 4));
    repeat (4) send(code(4'hF));
    repeat (3) tick();

    // Low clamp and back navigation
    start();
    send(dig(16'h0001, 1));
    send(dig(16'h0003, 2));
    send(code(4'hA));
    tick();
    chk_step("back_to_bip_time", 8'h02);
    send(code(4'hA));
    tick();
    chk_step("back_to_bip_en", 8'h01);
    send(code(4'hA));
    tick();
    chk_step("back_stays_bip_en", 8'h01);
    send(dig(16'h0000, 1));
    tick();
    chk_step("bip_en_accept", 8'h02);
    c_exp = '{bip_status: 1'b0, bip_time: 7'd5, tranca_aut_time: 7'd30,
              senha_master: dig(16'h9999, 4)};
    sb_q.push_back(mk(1'b1, c_exp, users_cur));
    send(code(4'hB));
    repeat (3) tick();

    // User index handling
    start();
    repeat (6) send(code(4'hF));
    tick();
    chk_step("user_idx2", 8'h07);
    send(dig(16'h0012, 2));
    tick();
    chk_step("short_pass_rejected", 8'h07);
    send(dig(16'h1234, 4));
    tick();
    chk_step("user_idx3", 8'h08);
    send(code(4'hA));
    tick();
    chk_step("user_back_idx2", 8'h07);
    u_exp    = users_cur;
    u_exp[2] = dig(16'h1234, 4);
    sb_q.push_back(mk(1'b1, cfg_cur, u_exp));
    send(code(4'hB));
    repeat (3) tick();

    // Ignore code, then cancel discards edits
    start();
    send(code(4'hE));
    tick();
    chk_step("ignore_code", 8'h01);
    send(dig(16'h0001, 1));
    send(dig(16'h0009, 2));
    sb_q.push_back(mk(1'b0, cfg_cur, users_cur));
    send(code(4'hC));
    repeat (3) tick();

    // Inactivity timeout
    sb_q.push_back(mk(1'b0, cfg_cur, users_cur));
    setup_on = 1'b1;
    tick();
    setup_on = 1'b0;
    n = 0;
    while (!setup_abort && n < 40) begin
      tick();
      n++;
    end
    check("timeout_latency", 320'(n), 320'(17));
    repeat (3) tick();

    // Strobe on the timeout cycle wins
    setup_on = 1'b1;
    tick();
    setup_on = 1'b0;
    repeat (15) tick();
    send(dig(16'h0001, 1));
    tick();
    chk_step("strobe_wins_step", 8'h02);
    repeat (8) tick();
    check("strobe_wins_no_abort", 320'(setup_abort), 320'(0));
    sb_q.push_back(mk(1'b0, cfg_cur, users_cur));
    send(code(4'hC));
    repeat (3) tick();

    // Asynchronous reset mid-edit
    start();
    send(dig(16'h0000, 1));
    rst = 1'b0;
    #1;
    check("midrst_display_en", 320'(display_en), 320'(0));
    check("midrst_bcd", 320'(bcd_pac), 320'(24'hFFFFFF));
    check("midrst_cfg", 320'(cfg_new), 320'(factory));
    tick();
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_idle", 320'(display_en), 320'(0));

    check("scoreboard_empty", 320'(sb_q.size()), 320'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
